// File: rtl/pzcorebus_pkg.sv
// Shared bus types, default configuration and command classification.
// Optional feature macro used by the remapper: PZCOREBUS_ID_REMAPPER_ERROR_CHECK_EN.
package pzcorebus_pkg;

    typedef struct packed {
        int id_width;
        int addr_width;
        int data_width;
        int length_width;
        int info_width;
    } pzcorebus_config;

    localparam pzcorebus_config PZCOREBUS_DEFAULT_CONFIG = '{
        id_width:     8,
        addr_width:   16,
        data_width:   32,
        length_width: 4,
        info_width:   2
    };

    typedef enum logic [2:0] {
        PZCOREBUS_READ             = 3'd0,
        PZCOREBUS_WRITE            = 3'd1,
        PZCOREBUS_WRITE_NON_POSTED = 3'd2,
        PZCOREBUS_BROADCAST        = 3'd3,
        PZCOREBUS_ATOMIC           = 3'd4,
        PZCOREBUS_MESSAGE          = 3'd5
    } pzcorebus_command_type;

    typedef enum logic [0:0] {
        PZCOREBUS_RESPONSE           = 1'b0,
        PZCOREBUS_RESPONSE_WITH_DATA = 1'b1
    } pzcorebus_response_type;

    // Commands that will later receive a response and so need a tag.
    function automatic logic is_response_required(pzcorebus_command_type cmd);
        return (cmd == PZCOREBUS_READ)
            || (cmd == PZCOREBUS_WRITE_NON_POSTED)
            || (cmd == PZCOREBUS_ATOMIC);
    endfunction

endpackage

// File: rtl/pzcorebus_if.sv
// Command / data / response bus with initiator (master) and target (slave) views.
// Widths come from the bus configuration parameter.
interface pzcorebus_if #(
    parameter pzcorebus_pkg::pzcorebus_config BUS_CONFIG =
        pzcorebus_pkg::PZCOREBUS_DEFAULT_CONFIG
);
    localparam int IW = BUS_CONFIG.id_width;
    localparam int AW = BUS_CONFIG.addr_width;
    localparam int DW = BUS_CONFIG.data_width;
    localparam int LW = BUS_CONFIG.length_width;
    localparam int NW = BUS_CONFIG.info_width;

    logic                                 mcmd_valid;
    logic                                 scmd_accept;
    pzcorebus_pkg::pzcorebus_command_type mcmd;
    logic [IW-1:0]                        mid;
    logic [AW-1:0]                        maddr;
    logic [LW-1:0]                        mlength;
    logic [NW-1:0]                        minfo;

    logic                                 mdata_valid;
    logic                                 sdata_accept;
    logic [DW-1:0]                        mdata;
    logic                                 mdata_last;

    logic                                  sresp_valid;
    logic                                  mresp_accept;
    pzcorebus_pkg::pzcorebus_response_type sresp;
    logic [IW-1:0]                         sid;
    logic [DW-1:0]                         sdata;
    logic                                  sresp_last;

    modport master (
        output mcmd_valid, mcmd, mid, maddr, mlength, minfo,
        output mdata_valid, mdata, mdata_last,
        output mresp_accept,
        input  scmd_accept, sdata_accept,
        input  sresp_valid, sresp, sid, sdata, sresp_last
    );

    modport slave (
        input  mcmd_valid, mcmd, mid, maddr, mlength, minfo,
        input  mdata_valid, mdata, mdata_last,
        input  mresp_accept,
        output scmd_accept, sdata_accept,
        output sresp_valid, sresp, sid, sdata, sresp_last
    );
endinterface

// File: rtl/pzcorebus_id_remapper_free_list.sv
// Tag pool: free vector, lowest-free encoder, empty flag, outstanding count.
// PZCOREBUS_ID_REMAPPER_ERROR_CHECK_EN adds a free-state query port.
module pzcorebus_id_remapper_free_list #(
    parameter int TAG_WIDTH = 2
)(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_alloc,
    input  logic                 i_free,
    input  logic [TAG_WIDTH-1:0] i_free_tag,
`ifdef PZCOREBUS_ID_REMAPPER_ERROR_CHECK_EN
    input  logic [TAG_WIDTH-1:0] i_query_tag,
    output logic                 o_query_free,
`endif
    output logic [TAG_WIDTH-1:0] o_tag,
    output logic                 o_empty,
    output logic [TAG_WIDTH:0]   o_outstanding
);
    localparam int ENTRIES = 2 ** TAG_WIDTH;
    localparam logic [TAG_WIDTH:0] MAX_COUNT = ENTRIES[TAG_WIDTH:0];

    logic [ENTRIES-1:0] free_q;
    logic [ENTRIES-1:0] free_d;
    logic [TAG_WIDTH:0] count_q;
    logic [TAG_WIDTH:0] count_d;

    // Lowest-index free entry; scanning downward leaves the lowest hit.
    always_comb begin
        o_tag = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (free_q[i]) begin
                o_tag = TAG_WIDTH'(i);
            end
        end
    end

    assign o_empty       = (free_q == '0);
    assign o_outstanding = count_q;

`ifdef PZCOREBUS_ID_REMAPPER_ERROR_CHECK_EN
    assign o_query_free = free_q[i_query_tag];
`endif

    // Release and claim; the two never hit the same index in one cycle.
    always_comb begin
        free_d = free_q;
        if (i_free) begin
            free_d[i_free_tag] = 1'b1;
        end
        if (i_alloc) begin
            free_d[o_tag] = 1'b0;
        end
    end

    // Saturating count of allocated tags.
    always_comb begin
        count_d = count_q;
        if (i_alloc && !i_free && (count_q != MAX_COUNT)) begin
            count_d = count_q + 1'b1;
        end else if (i_free && !i_alloc && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pool state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            free_q  <= '1;
            count_q <= '0;
        end else begin
            free_q  <= free_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/pzcorebus_id_remapper.sv
// Compresses wide request IDs into a small tag pool and restores them on responses.
// PZCOREBUS_ID_REMAPPER_ERROR_CHECK_EN drops responses to free tags and flags o_error.
module pzcorebus_id_remapper
    import pzcorebus_pkg::*;
#(
    parameter pzcorebus_config BUS_CONFIG = PZCOREBUS_DEFAULT_CONFIG,
    parameter int ID_WIDTH  = BUS_CONFIG.id_width,
    parameter int TAG_WIDTH = 2
)(
    input  logic               i_clk,
    input  logic               i_rst_n,
    pzcorebus_if.slave         slave_if,
    pzcorebus_if.master        master_if,
    output logic [TAG_WIDTH:0] o_outstanding,
    output logic               o_busy,
    output logic               o_error
);
    localparam int ENTRIES = 2 ** TAG_WIDTH;

    logic                 rsp_req;
    logic                 empty;
    logic                 stall;
    logic                 alloc;
    logic                 free_strobe;
    logic                 rsp_drop;
    logic [TAG_WIDTH-1:0] alloc_tag;
    logic [TAG_WIDTH-1:0] rsp_tag;
    logic [ID_WIDTH-1:0]  id_table_q [ENTRIES];

    assign rsp_req = is_response_required(slave_if.mcmd);
    assign stall   = rsp_req && empty;
    assign rsp_tag = master_if.sid[TAG_WIDTH-1:0];

    assign master_if.mcmd_valid = slave_if.mcmd_valid && !stall;
    assign slave_if.scmd_accept = master_if.scmd_accept && !stall;
    assign master_if.mcmd       = slave_if.mcmd;
    assign master_if.mid        = rsp_req ? ID_WIDTH'(alloc_tag) : '0;
    assign master_if.maddr      = slave_if.maddr;
    assign master_if.mlength    = slave_if.mlength;
    assign master_if.minfo      = slave_if.minfo;

    assign master_if.mdata_valid = slave_if.mdata_valid;
    assign master_if.mdata       = slave_if.mdata;
    assign master_if.mdata_last  = slave_if.mdata_last;
    assign slave_if.sdata_accept = master_if.sdata_accept;

    assign slave_if.sresp_valid   = master_if.sresp_valid && !rsp_drop;
    assign slave_if.sresp         = master_if.sresp;
    assign slave_if.sid           = id_table_q[rsp_tag];
    assign slave_if.sdata         = master_if.sdata;
    assign slave_if.sresp_last    = master_if.sresp_last;
    assign master_if.mresp_accept = rsp_drop || slave_if.mresp_accept;

    assign alloc = master_if.mcmd_valid && master_if.scmd_accept && rsp_req;
    assign free_strobe = master_if.sresp_valid && master_if.mresp_accept
                      && master_if.sresp_last && !rsp_drop;

    pzcorebus_id_remapper_free_list #(
        .TAG_WIDTH (TAG_WIDTH)
    ) u_free_list (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_alloc       (alloc),
        .i_free        (free_strobe),
        .i_free_tag    (rsp_tag),
`ifdef PZCOREBUS_ID_REMAPPER_ERROR_CHECK_EN
        .i_query_tag   (rsp_tag),
        .o_query_free  (rsp_drop),
`endif
        .o_tag         (alloc_tag),
        .o_empty       (empty),
        .o_outstanding (o_outstanding)
    );

    assign o_busy = (o_outstanding != '0);

    // Remember the original ID of each allocated tag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                id_table_q[i] <= '0;
            end
        end else if (alloc) begin
            id_table_q[alloc_tag] <= slave_if.mid;
        end
    end

`ifdef PZCOREBUS_ID_REMAPPER_ERROR_CHECK_EN
    logic error_q;
    logic error_d;

    // A response carrying an unallocated tag latches the error until reset.
    always_comb begin
        error_d = error_q;
        if (master_if.sresp_valid && rsp_drop) begin
            error_d = 1'b1;
        end
    end

    // Sticky error register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign o_error = error_q;
`else
    assign rsp_drop = 1'b0;
    assign o_error  = 1'b0;
`endif
endmodule
